// File: rtl/pixy_bus_pkg.sv
// Shared encodings and widths for the 68000 bus-cycle logic (dtack_sequencer and
// its timeout counter).
package pixy_bus_pkg;

    localparam int WAIT_W = 4;
    localparam int TMO_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_TMO    = 3'd3,
        ST_ACK    = 3'd4,
        ST_ERR    = 3'd5
    } bus_state_t;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_ROM  = 2'd1,
        RGN_RAM  = 2'd2,
        RGN_IO   = 2'd3
    } region_t;

    // ROM wins over RAM, RAM wins over I/O when the decoder reports overlaps.
    function automatic region_t decode_region(input logic rom, input logic ram, input logic io);
        region_t rgn;
        if (rom) begin
            rgn = RGN_ROM;
        end else if (ram) begin
            rgn = RGN_RAM;
        end else if (io) begin
            rgn = RGN_IO;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/dtack_sequencer_timeout.sv
// bus_timeout_counter: counts clocks of an unmapped bus cycle and flags the
// terminal count that triggers BERR. Only instantiated under BUS_TIMEOUT_EN.
module bus_timeout_counter
    import pixy_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_count;

    // Counter saturates at the terminal value until the next clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != TC_VAL)) begin
            r_count <= r_count + TMO_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/dtack_sequencer.sv
// dtack_sequencer: 68000 bus-cycle controller with per-region wait states and a
// stepper-gated DTACK. Optional BERR timeout for unmapped cycles: BUS_TIMEOUT_EN.
module dtack_sequencer
    import pixy_bus_pkg::*;
#(
    parameter int WAIT_ROM       = 1,
    parameter int WAIT_RAM       = 0,
    parameter int WAIT_IO        = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic CPUCLK_IN,
    input  logic RUN_IN,
    input  logic AS_N_IN,
    input  logic UDS_N_IN,
    input  logic LDS_N_IN,
    input  logic SEL_ROM_IN,
    input  logic SEL_RAM_IN,
    input  logic SEL_IO_IN,
    input  logic EXEC_IN,
    output logic DTACK_N,
    output logic BERR_N,
    output logic CYCLE_ACTIVE,
    output logic CYCLE_DONE
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 1023)) begin : g_bad_timeout
        $error("dtack_sequencer: TIMEOUT_CYCLES must be 1..1023");
    end

    bus_state_t          r_state;
    bus_state_t          w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic                w_request;
    region_t             w_region;
    logic                w_done;
    logic                r_dtack_n;
    logic                r_cycle_active;
    logic                r_cycle_done;

    // Unmapped regions fall back to the I/O wait count when there is no timeout path.
    function automatic logic [WAIT_W-1:0] wait_for_region(input region_t rgn);
        logic [WAIT_W-1:0] cnt;
        case (rgn)
            RGN_ROM: cnt = WAIT_W'(WAIT_ROM);
            RGN_RAM: cnt = WAIT_W'(WAIT_RAM);
            RGN_IO:  cnt = WAIT_W'(WAIT_IO);
            default: cnt = WAIT_W'(WAIT_IO);
        endcase
        return cnt;
    endfunction

    assign w_request = !AS_N_IN && (!UDS_N_IN || !LDS_N_IN);
    assign w_region  = decode_region(SEL_ROM_IN, SEL_RAM_IN, SEL_IO_IN);

`ifdef BUS_TIMEOUT_EN
    logic w_tmo_clear;
    logic w_tmo_enable;
    logic w_tmo_tc;
    logic r_berr_n;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (CPUCLK_IN),
        .i_rst_n  (RUN_IN),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_tc     (w_tmo_tc)
    );
`endif

    // Next-state, wait-counter and handshake decisions.
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_done         = 1'b0;
`ifdef BUS_TIMEOUT_EN
        w_tmo_clear    = 1'b0;
        w_tmo_enable   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (AS_N_IN) begin
                    w_next_state = ST_IDLE;
`ifdef BUS_TIMEOUT_EN
                end else if (w_region == RGN_NONE) begin
                    w_tmo_clear  = 1'b1;
                    w_next_state = ST_TMO;
`endif
                end else begin
                    w_wait_cnt_nxt = wait_for_region(w_region);
                    w_next_state   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A zero count with EXEC_IN low is the single-step pause; it never times out.
                if (AS_N_IN) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt != {WAIT_W{1'b0}}) begin
                    w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
                end else if (EXEC_IN) begin
                    w_next_state = ST_ACK;
                    w_done       = 1'b1;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
`ifdef BUS_TIMEOUT_EN
            ST_TMO: begin
                if (AS_N_IN) begin
                    w_next_state = ST_IDLE;
                end else if (w_tmo_tc) begin
                    w_next_state = ST_ERR;
                    w_done       = 1'b1;
                end else begin
                    w_tmo_enable = 1'b1;
                end
            end
            ST_ERR: begin
                if (AS_N_IN) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ERR;
                end
            end
`endif
            ST_ACK: begin
                if (AS_N_IN) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ACK;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; outputs decode the upcoming state.
    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= '0;
            r_dtack_n      <= 1'b1;
            r_cycle_active <= 1'b0;
            r_cycle_done   <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_dtack_n      <= (w_next_state != ST_ACK);
            r_cycle_active <= (w_next_state == ST_WAIT);
            r_cycle_done   <= w_done;
        end
    end

`ifdef BUS_TIMEOUT_EN
    // BERR strobe register.
    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_berr_n <= 1'b1;
        end else begin
            r_berr_n <= (w_next_state != ST_ERR);
        end
    end

    assign BERR_N = r_berr_n;
`else
    assign BERR_N = 1'b1;
`endif

    assign DTACK_N      = r_dtack_n;
    assign CYCLE_ACTIVE = r_cycle_active;
    assign CYCLE_DONE   = r_cycle_done;

endmodule

// File: tb/tb_dtack_sequencer.sv
// Directed self-checking bench for dtack_sequencer (WAIT_ROM=1, WAIT_RAM=0,
// WAIT_IO=3, TIMEOUT_CYCLES=16); expectations follow BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_dtack_sequencer;

    logic clk = 1'b0;
    logic run_n, as_n, uds_n, lds_n, sel_rom, sel_ram, sel_io, exec_in;
    logic dtack_n, berr_n, cyc_active, cyc_done;

    int errors = 0;
    int checks = 0;
    int done_cnt, active_cnt, overlap_cnt = 0;

    dtack_sequencer #(
        .WAIT_ROM(1), .WAIT_RAM(0), .WAIT_IO(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .CPUCLK_IN(clk), .RUN_IN(run_n), .AS_N_IN(as_n), .UDS_N_IN(uds_n),
        .LDS_N_IN(lds_n), .SEL_ROM_IN(sel_rom), .SEL_RAM_IN(sel_ram),
        .SEL_IO_IN(sel_io), .EXEC_IN(exec_in), .DTACK_N(dtack_n),
        .BERR_N(berr_n), .CYCLE_ACTIVE(cyc_active), .CYCLE_DONE(cyc_done)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        sel_rom = 1'b0; sel_ram = 1'b0; sel_io = 1'b0;
    endtask

    task automatic start_cycle(input logic rom, input logic ram, input logic io, input logic ex);
        sel_rom = rom; sel_ram = ram; sel_io = io; exec_in = ex;
        as_n = 1'b0; uds_n = 1'b0;
        done_cnt = 0; active_cnt = 0;
    endtask

    // One clock: sample outputs on the falling edge.
    task automatic step();
        @(negedge clk);
        if (cyc_done === 1'b1) done_cnt++;
        if (cyc_active === 1'b1) active_cnt++;
        if (dtack_n === 1'b0 && berr_n === 1'b0) overlap_cnt++;
    endtask

    // lat = number of rising edges after the request edge k at which a strobe fell; -1 on timeout.
    task automatic run_until(input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (dtack_n === 1'b0 || berr_n === 1'b0) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_bus(); exec_in = 1'b0; run_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b expected 1", dtack_n); end
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr: got %b expected 1", berr_n); end
        checks++; if (cyc_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", cyc_active); end
        checks++; if (cyc_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", cyc_done); end
        run_n = 1'b1;
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL idle_dtack: got %b expected 1", dtack_n); end
    endtask

    task automatic test_ram_read();
        int lat;
        int held_bad = 0;
        start_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_until(20, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ram_latency: got %0d expected 2", lat); end
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL ram_berr: got %b expected 1", berr_n); end
        repeat (3) begin
            step();
            if (dtack_n !== 1'b0) held_bad++;
        end
        checks++; if (held_bad !== 0) begin errors++; $display("FAIL ram_hold: got %0d high samples expected 0", held_bad); end
        checks++; if (active_cnt !== 1) begin errors++; $display("FAIL ram_active: got %0d expected 1", active_cnt); end
        idle_bus();
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL ram_release: got %b expected 1", dtack_n); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ram_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_io_wait();
        int lat;
        start_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        run_until(20, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL io_latency: got %0d expected 5", lat); end
        checks++; if (active_cnt !== 4) begin errors++; $display("FAIL io_active: got %0d expected 4", active_cnt); end
        idle_bus();
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL io_release: got %b expected 1", dtack_n); end
    endtask

    task automatic test_exec_hold();
        int bad = 0;
        start_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (22) begin
            step();
            if (dtack_n !== 1'b1 || berr_n !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_strobe: got %0d low samples expected 0", bad); end
        checks++; if (cyc_active !== 1'b1) begin errors++; $display("FAIL hold_active: got %b expected 1", cyc_active); end
        exec_in = 1'b1;
        step();
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL hold_dtack: got %b expected 0", dtack_n); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL hold_done: got %0d expected 1", done_cnt); end
        idle_bus();
        step();
    endtask

    task automatic test_unmapped();
        int lat;
        start_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_until(40, lat);
`ifdef BUS_TIMEOUT_EN
        checks++; if (lat !== 17) begin errors++; $display("FAIL tmo_latency: got %0d expected 17", lat); end
        checks++; if (berr_n !== 1'b0) begin errors++; $display("FAIL tmo_berr: got %b expected 0", berr_n); end
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL tmo_dtack: got %b expected 1", dtack_n); end
`else
        checks++; if (lat !== 5) begin errors++; $display("FAIL unmapped_latency: got %0d expected 5", lat); end
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL unmapped_dtack: got %b expected 0", dtack_n); end
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL unmapped_berr: got %b expected 1", berr_n); end
`endif
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL unmapped_done: got %0d expected 1", done_cnt); end
        idle_bus();
        step();
        checks++; if ({dtack_n, berr_n} !== 2'b11) begin errors++; $display("FAIL unmapped_release: got %b expected 11", {dtack_n, berr_n}); end
    endtask

    task automatic test_priority();
        int lat;
        start_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        run_until(20, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL prio_latency: got %0d expected 3", lat); end
        idle_bus();
        step();
    endtask

    task automatic test_abort();
        int bad = 0;
        start_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step();
        idle_bus();
        repeat (10) begin
            step();
            if (dtack_n !== 1'b1 || berr_n !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_strobe: got %0d low samples expected 0", bad); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        checks++; if (cyc_active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b expected 0", cyc_active); end
    endtask

    task automatic test_reset_in_ack();
        int lat;
        start_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_until(20, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rst_ack_latency: got %0d expected 2", lat); end
        run_n = 1'b0;
        #1;
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rst_ack_dtack: got %b expected 1", dtack_n); end
        checks++; if (cyc_done !== 1'b0) begin errors++; $display("FAIL rst_ack_done: got %b expected 0", cyc_done); end
        idle_bus();
        @(negedge clk);
        run_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_until(20, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first: got %0d expected 2", lat); end
        idle_bus();
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL b2b_release: got %b expected 1", dtack_n); end
        start_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_until(20, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_second: got %0d expected 2", lat); end
        idle_bus();
        step();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_io_wait();
        test_exec_hold();
        test_unmapped();
        test_priority();
        test_abort();
        test_reset_in_ack();
        test_back_to_back();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dtack_sequencer.md
# dtack_sequencer

Bus-cycle controller for the 68000 board: watches each CPU bus cycle, decodes the selected region, and inserts per-region wait states. When the single-step handshake allows, it acknowledges the cycle with DTACK. Unmapped cycles end in a bus error after a timeout. It sits between the address decoder and the CPU, and exchanges the cycle-pending / execute-permit handshake with the stepper block.

## Interface
Parameters:
- WAIT_ROM, 1: wait states for ROM cycles (0-15).
- WAIT_RAM, 0: wait states for RAM cycles (0-15).
- WAIT_IO, 3: wait states for I/O cycles (0-15).
- TIMEOUT_CYCLES, 1023: clocks before an unmapped cycle gets BERR (1-1023).

Ports:
- CPUCLK_IN, input, 1: CPU clock; all state changes on its rising edge.
- RUN_IN, input, 1: reset, asynchronous, active-low.
- AS_N_IN, input, 1: 68000 address strobe, active-low.
- UDS_N_IN, input, 1: upper data strobe, active-low.
- LDS_N_IN, input, 1: lower data strobe, active-low.
- SEL_ROM_IN, input, 1: decoder hit, ROM.
- SEL_RAM_IN, input, 1: decoder hit, RAM.
- SEL_IO_IN, input, 1: decoder hit, I/O.
- EXEC_IN, input, 1: execute permit from the stepper.
- DTACK_N, output, 1: data acknowledge to CPU, active-low, registered.
- BERR_N, output, 1: bus error to CPU, active-low, registered.
- CYCLE_ACTIVE, output, 1: cycle pending; drives the stepper enable input.
- CYCLE_DONE, output, 1: one-clock pulse when a cycle is acknowledged or errored.

## Operation
- States: IDLE, DECODE, WAIT, TMO, ACK, ERR.
- IDLE
  - Request = AS_N_IN low and (UDS_N_IN low or LDS_N_IN low).
  - On a request, go to DECODE.
- DECODE (one clock)
  - Select priority: ROM > RAM > IO.
  - On a hit, load the 4-bit wait counter with that region's WAIT_x and go to WAIT.
  - With no hit, clear the 10-bit timeout counter and go to TMO.
- WAIT
  - CYCLE_ACTIVE = 1.
  - Counter not zero: decrement it.
  - Counter zero and EXEC_IN = 1: go to ACK, DTACK_N <= 0, pulse CYCLE_DONE.
  - Counter zero and EXEC_IN = 0: stay in WAIT indefinitely. This is the step pause; there is no timeout here.
- TMO
  - Increment the timeout counter.
  - When it reaches TIMEOUT_CYCLES-1: go to ERR, BERR_N <= 0, pulse CYCLE_DONE.
- ACK / ERR
  - Hold the strobe output low until AS_N_IN is sampled high.
  - On that edge, drive it high and return to IDLE.
- Abort: AS_N_IN sampled high in DECODE, WAIT or TMO returns to IDLE on that edge. No DTACK, no BERR, no CYCLE_DONE.
- Reset: asynchronously forces IDLE, DTACK_N = 1, BERR_N = 1, CYCLE_ACTIVE = 0, CYCLE_DONE = 0, both counters = 0. This applies mid-cycle too; the CPU is reset alongside.
- DTACK_N and BERR_N are never low together.
- Select inputs are sampled only in DECODE; changes afterwards are ignored.

## Timing
- Request seen at edge k → DECODE after k → WAIT after k+1 with count W.
- DTACK_N falls at edge k+2+W when EXEC_IN is high at that edge. With W = 0, DTACK_N falls at k+2.
- EXEC_IN low at that edge delays DTACK one clock per low sample.
- Unmapped cycle: BERR_N falls at edge k+1+TIMEOUT_CYCLES.
- The strobe output rises on the same edge at which AS_N_IN is first sampled high. The earliest next request is then taken the following edge.
- CYCLE_ACTIVE is registered from state. It is high exactly while the state is WAIT.

## Configuration
- BUS_TIMEOUT_EN defined:
  - TMO and ERR states, timeout counter and BERR generation are present.
- BUS_TIMEOUT_EN undefined:
  - BERR_N is tied to 1 and TMO/ERR are removed.
  - Unmapped cycles are treated as I/O: WAIT_IO wait states, DTACK, stepper-gated.

## Structure
- Shared package pixy_bus_pkg holds:
  - state encoding constants;
  - region codes (ROM/RAM/IO/NONE);
  - the 4-bit wait-count and 10-bit timeout widths.
- One natural sub-module: bus_timeout_counter. It is instantiated only under BUS_TIMEOUT_EN and exposes clear, enable and terminal-count.

## Test plan
- Reset released, then a RAM read with EXEC_IN = 1 → DTACK_N low 2 clocks after AS_N_IN low. It stays low until AS_N_IN rises, then high on that edge. CYCLE_DONE pulses once.
- I/O cycle with WAIT_IO = 3 → DTACK_N low at k+5. CYCLE_ACTIVE is high for 4 clocks.
- ROM cycle with EXEC_IN held low 20 clocks → stays in WAIT with CYCLE_ACTIVE high and no BERR. DTACK follows 1 clock after EXEC_IN rises.
- No select with TIMEOUT_CYCLES = 16 → BERR_N low at k+17 and DTACK_N stays high. Without BUS_TIMEOUT_EN → DTACK_N low at k+5 instead.
- SEL_ROM_IN and SEL_IO_IN both high → ROM wait count used (DTACK at k+3).
- Abort and reset
  - AS_N_IN released during WAIT → IDLE, no DTACK, no CYCLE_DONE.
  - RUN_IN pulsed low during ACK → DTACK_N high immediately, state IDLE.
